// File: rtl/mask_apb_writer.sv
// APB3 slave that loads the pixel-valid mask into the mask RAM write port.
// A 32-bit DATA write becomes four byte writes at an auto-incrementing pointer. A fill engine sets or clears the whole RAM.
`timescale 1ns/1ps
module mask_apb_writer #(
   parameter int MASK_W = 112,
   parameter int MASK_H = 112,
   parameter int AW     = 11
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          PSEL,
   input  logic          PENABLE,
   input  logic          PWRITE,
   input  logic [7:0]    PADDR,
   input  logic [31:0]   PWDATA,
   output logic [31:0]   PRDATA,
   output logic          PREADY,
   output logic          PSLVERR,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [7:0]    ram_wdata,
   output logic          mask_en
);

   localparam int BPR   = MASK_W / 8;
   localparam int DEPTH = BPR * MASK_H;
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_PTR    = 3'd2;
   localparam logic [2:0] OFF_DATA   = 3'd3;

   typedef enum logic [1:0] {IDLE, BURST, FILL} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_next, ptr_load;
   logic [31:0]   word_q;
   logic [1:0]    beat_q;
   logic          err_q, fill_val_q, mask_en_q;

   logic [2:0]    off;
   logic          busy, access, wr_done;
   logic          wr_ctrl, wr_status, wr_ptr, wr_data, fill_req;
   logic          unused_addr;

   // Handshake: a transfer completes in the access phase (PSEL & PENABLE)
   // when PREADY is high; only PTR/DATA writes stall, and only while busy.
   assign off     = PADDR[4:2];
   assign busy    = (state_q != IDLE);
   assign access  = PSEL & PENABLE;
   assign PREADY  = ~(access & PWRITE & busy & ((off == OFF_PTR) | (off == OFF_DATA)));
   assign PSLVERR = access & PADDR[4];
   assign wr_done = access & PWRITE & PREADY;

   assign wr_ctrl   = wr_done & (off == OFF_CTRL);
   assign wr_status = wr_done & (off == OFF_STATUS);
   assign wr_ptr    = wr_done & (off == OFF_PTR);
   assign wr_data   = wr_done & (off == OFF_DATA);
   assign fill_req  = wr_ctrl & PWDATA[0];

   assign unused_addr = ^{PADDR[7:5], PADDR[1:0]};

   assign ptr_next = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
   // Loaded values fall below 2*DEPTH, so a single subtract gives mod DEPTH.
   assign ptr_load = ({1'b0, PWDATA[AW-1:0]} >= DEPTH_W) ? PWDATA[AW-1:0] - DEPTH_W[AW-1:0]
                                                        : PWDATA[AW-1:0];
   assign mask_en  = mask_en_q;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_waddr = ptr_q;
      ram_wdata = 8'd0;
      case (state_q)
         IDLE: begin
            if (wr_data)       state_d = BURST;
            else if (fill_req) state_d = FILL;
         end
         BURST: begin
            ram_we    = 1'b1;
            ram_wdata = word_q[{beat_q, 3'b000} +: 8];
            if (beat_q == 2'd3) state_d = IDLE;
         end
         FILL: begin
            ram_we    = 1'b1;
            ram_wdata = {8{fill_val_q}};
            if (ptr_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         ptr_q      <= '0;
         word_q     <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         fill_val_q <= 1'b0;
         mask_en_q  <= 1'b0;
      end else begin
         if (busy)          ptr_q <= ptr_next;
         else if (wr_ptr)   ptr_q <= ptr_load;
         else if (fill_req) ptr_q <= '0;

         if (state_q == BURST) beat_q <= beat_q + 2'd1;
         else                  beat_q <= '0;

         if (wr_data) word_q <= PWDATA;

         if (wr_ctrl) begin
            fill_val_q <= PWDATA[1];
            mask_en_q  <= PWDATA[2];
         end

         // A fill request while busy is dropped and flagged instead.
         if (fill_req && busy)             err_q <= 1'b1;
         else if (wr_status && PWDATA[1])  err_q <= 1'b0;
      end
   end

   always_comb begin
      PRDATA = 32'd0;
      if (access && !PWRITE) begin
         case (off)
            OFF_CTRL:   PRDATA = {29'd0, mask_en_q, fill_val_q, 1'b0};
            OFF_STATUS: PRDATA = {30'd0, err_q, busy};
            OFF_PTR:    PRDATA = {{(32 - AW){1'b0}}, ptr_q};
            default:    PRDATA = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mask_apb_writer.sv
// Self-checking bench for mask_apb_writer: a transaction-level model predicts
// RAM writes, busy windows, register reads and wait states.
`timescale 1ns/1ps
module tb_mask_apb_writer;

   localparam int AW    = 11;
   localparam int DEPTH = 1568;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0]    PADDR = 8'd0;
   logic [31:0]   PWDATA = 32'd0;
   logic [31:0]   PRDATA;
   logic          PREADY, PSLVERR, ram_we, mask_en;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_wdata;

   mask_apb_writer #(.MASK_W(112), .MASK_H(112), .AW(AW)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .ram_we(ram_we),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .mask_en(mask_en)
   );

   always #5 PCLK = ~PCLK;

   // Model state: expected RAM writes {addr, data}, registers, busy window.
   logic [AW+7:0] exp_q[$];
   int            ptr_m = 0;
   logic          err_m = 1'b0, fill_val_m = 1'b0, mask_en_m = 1'b0;
   int            cyc = 0, busy_end = 0, n_wr = 0;
   bit            chk_on = 1'b0;
   int            total = 0, bad = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: a RAM write happens exactly in busy cycles, matching the queue.
   always @(negedge PCLK) begin
      if (chk_on) begin
         logic [AW+7:0] e;
         check("ram_we", 32'(ram_we), 32'(cyc < busy_end));
         if (ram_we) begin
            n_wr++;
            check("addr_range", 32'(int'(ram_waddr) < DEPTH), 32'd1);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL ram_write: got write addr %0d, expected none", ram_waddr);
            end else begin
               e = exp_q.pop_front();
               check("ram_waddr", 32'(ram_waddr), 32'(e[AW+7:8]));
               check("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
            end
         end
         check("mask_en", 32'(mask_en), 32'(mask_en_m));
      end
   end

   task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits);
      logic [2:0]  off;
      logic        bsy, exp_rdy, ok, done;
      logic [31:0] exp_rd;
      off = addr[4:2];
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0; done = 1'b0; ok = 1'b0; rdata = 32'd0; bsy = 1'b0;
      while (!done) begin
         @(negedge PCLK);
         bsy     = (cyc < busy_end);
         exp_rdy = !(bsy && wr && (off == 3'd2 || off == 3'd3));
         check("pready", 32'(PREADY), 32'(exp_rdy));
         if (PREADY) begin
            done = 1'b1; ok = 1'b1; rdata = PRDATA;
            check("pslverr", 32'(PSLVERR), 32'(addr[4]));
            if (!wr && !(off == 3'd2 && bsy)) begin
               case (off)
                  3'd0:    exp_rd = {29'd0, mask_en_m, fill_val_m, 1'b0};
                  3'd1:    exp_rd = {30'd0, err_m, bsy};
                  3'd2:    exp_rd = 32'(ptr_m);
                  default: exp_rd = 32'd0;
               endcase
               check("prdata", PRDATA, exp_rd);
            end
         end else begin
            waits++;
            if (waits > 4000) begin
               total++; bad++;
               $display("FAIL apb_timeout: got %0d wait states, expected completion", waits);
               done = 1'b1;
            end
         end
         @(posedge PCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      if (ok && wr) begin
         case (off)
            3'd0: begin
               fill_val_m = wdata[1];
               mask_en_m  = wdata[2];
               if (wdata[0]) begin
                  if (bsy) err_m = 1'b1;
                  else begin
                     ptr_m = 0;
                     for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), {8{wdata[1]}}});
                     busy_end = cyc + DEPTH;
                  end
               end
            end
            3'd1: if (wdata[1]) err_m = 1'b0;
            3'd2: ptr_m = int'(wdata[AW-1:0]) % DEPTH;
            3'd3: begin
               for (int i = 0; i < 4; i++) begin
                  exp_q.push_back({AW'(ptr_m), wdata[8*i +: 8]});
                  ptr_m = (ptr_m + 1) % DEPTH;
               end
               busy_end = cyc + 4;
            end
            default: ;
         endcase
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (cyc < busy_end && guard < 5000) begin
         @(posedge PCLK); #1;
         guard++;
      end
      if (guard >= 5000) begin
         total++; bad++;
         $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", guard);
      end
   endtask

   logic [31:0] rd, v;
   int          w, w2, wr0, kind, fills_left;
   logic [1:0]  lo;
   logic [2:0]  o;

   initial begin
      // Reset and reset-state outputs
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_prdata", PRDATA, 32'd0);
      check("rst_pready", 32'(PREADY), 32'd1);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_waddr", 32'(ram_waddr), 32'd0);
      check("rst_wdata", 32'(ram_wdata), 32'd0);
      check("rst_mask_en", 32'(mask_en), 32'd0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      chk_on  = 1'b1;

      apb(1'b0, 8'h04, 32'd0, rd, w);  check("status_after_rst", rd, 32'd0);
      apb(1'b0, 8'h00, 32'd0, rd, w);  check("ctrl_after_rst", rd, 32'd0);

      // Single word at 0x10
      apb(1'b1, 8'h08, 32'h10, rd, w);
      apb(1'b1, 8'h0C, 32'hA1B2C3D4, rd, w);
      check("model_first_beat", 32'(exp_q[0]), 32'({11'h010, 8'hD4}));
      check("model_last_beat", 32'(exp_q[3]), 32'({11'h013, 8'hA1}));
      wait_idle();
      apb(1'b0, 8'h08, 32'd0, rd, w);  check("ptr_after_word", rd, 32'h14);

      // Wrap at the top of the RAM, back-to-back words
      apb(1'b1, 8'h08, 32'd1566, rd, w);
      apb(1'b1, 8'h0C, 32'h44332211, rd, w);
      check("model_wrap_addr", 32'(exp_q[2]), 32'({11'd0, 8'h33}));
      apb(1'b1, 8'h0C, 32'h88776655, rd, w2);
      check("b2b_waits_in_range", 32'(w2 >= 1 && w2 <= 4), 32'd1);
      wait_idle();
      apb(1'b0, 8'h08, 32'd0, rd, w);  check("ptr_after_wrap", rd, 32'd6);

      // Fill with ones, mask enabled; a DATA write stalls until the fill ends
      wr0 = n_wr;
      apb(1'b1, 8'h00, 32'h7, rd, w);
      apb(1'b0, 8'h04, 32'd0, rd, w);  check("status_mid_fill", rd, 32'h1);
      apb(1'b1, 8'h0C, 32'hCAFEF00D, rd, w);
      check("model_data_after_fill", 32'(exp_q[0]), 32'({11'd0, 8'h0D}));
      wait_idle();
      check("fill_write_count", 32'(n_wr - wr0), 32'(DEPTH + 4));

      // Fill request during a burst sets err
      apb(1'b1, 8'h0C, 32'h01020304, rd, w);
      apb(1'b1, 8'h00, 32'h1, rd, w);
      apb(1'b0, 8'h04, 32'd0, rd, w);  check("status_err_busy", rd, 32'h3);
      wait_idle();
      apb(1'b1, 8'h04, 32'h2, rd, w);
      apb(1'b0, 8'h04, 32'd0, rd, w);  check("status_err_cleared", rd, 32'h0);

      // Unmapped offsets
      apb(1'b0, 8'h14, 32'd0, rd, w);  check("bad_read_data", rd, 32'd0);
      apb(1'b1, 8'h18, 32'hFFFFFFFF, rd, w);

      // Randomized traffic
      fills_left = 2;
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         lo   = 2'($urandom_range(0, 3));
         case (kind)
            0, 1: apb(1'b1, {3'b000, 3'd3, lo}, $urandom, rd, w);
            2:    apb(1'b1, {3'b000, 3'd2, lo}, 32'($urandom_range(0, 2047)), rd, w);
            3: begin
               v = 32'($urandom_range(0, 7)) & 32'h6;
               if (fills_left > 0 && $urandom_range(0, 3) == 0) begin
                  v = v | 32'h1;
                  fills_left--;
               end
               apb(1'b1, {3'b000, 3'd0, lo}, v, rd, w);
            end
            4:    apb(1'b1, {3'b000, 3'd1, lo}, $urandom, rd, w);
            5, 6: begin
               o = 3'($urandom_range(0, 3));
               apb(1'b0, {3'b000, o, lo}, 32'd0, rd, w);
            end
            7: begin
               o = 3'($urandom_range(4, 7));
               apb(1'($urandom_range(0, 1)), {3'b000, o, lo}, $urandom, rd, w);
            end
            8: begin
               wait_idle();
               apb(1'b0, {3'b000, 3'd2, lo}, 32'd0, rd, w);
            end
            default: repeat ($urandom_range(1, 6)) begin @(posedge PCLK); #1; end
         endcase
      end
      wait_idle();

      // Reset in the middle of a fill
      apb(1'b1, 8'h00, 32'h7, rd, w);
      repeat (100) begin @(posedge PCLK); #1; end
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      exp_q.delete();
      busy_end = 0; ptr_m = 0; err_m = 1'b0; fill_val_m = 1'b0; mask_en_m = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      repeat (3) begin @(posedge PCLK); #1; end
      apb(1'b0, 8'h04, 32'd0, rd, w);  check("status_after_abort", rd, 32'd0);
      apb(1'b0, 8'h08, 32'd0, rd, w);  check("ptr_after_abort", rd, 32'd0);

      wait_idle();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mask_apb_writer.md
Name: mask_apb_writer

Overview:
APB3 slave that lets the Cortex-M3 (MSS) load the 112x112 pixel-valid mask into the write port of the two-port mask RAM. The mask reader on the Stonyman side reads the same RAM asynchronously.
- Packs 32-bit APB data writes into byte-wide RAM writes, with an auto-incrementing pointer.
- Provides a hardware fill (clear/set-all) engine.
- Exports the mask-enable control bit.

Parameters:
MASK_W, 112, mask columns (multiple of 8)
MASK_H, 112, mask rows
AW, 11, RAM byte-address width; must satisfy 2^AW >= DEPTH
(derived, not overridable) BPR = MASK_W/8 = 14 bytes per row; DEPTH = BPR*MASK_H = 1568 bytes

Ports:
PCLK  in  1  system clock; all logic rising-edge
PRESETn  in  1  reset, synchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  8  byte offset; only [4:2] decoded, [1:0] ignored
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response
ram_we  out  1  RAM write strobe, one byte per cycle
ram_waddr  out  AW  RAM byte address
ram_wdata  out  8  RAM byte data
mask_en  out  1  mask enable to the Stonyman mask reader

Behaviour:
Reset:
- Reset is taken on PCLK when PRESETn=0.
- On reset: PRDATA=0, PREADY=1, PSLVERR=0, ram_we=0, ram_waddr=0, ram_wdata=0, mask_en=0.
- On reset: ptr=0, busy=0, err=0, FSM=IDLE.
- Reset mid-burst or mid-fill aborts immediately; no further ram_we.

Bit mapping:
- RAM byte a holds row a/BPR, columns 8*(a%BPR)+k for bit k.
- Bit = 1 means the pixel is valid.

Register map (offset):
- 0x00 CTRL, R/W.
  - bit0 FILL: write-1 starts fill; reads 0.
  - bit1 FILL_VAL.
  - bit2 MASK_EN, drives mask_en.
- 0x04 STATUS, RO.
  - bit0 busy.
  - bit1 err, sticky; cleared by writing 1 to bit1 of STATUS.
  - This W1C write is the only allowed write to 0x04.
- 0x08 PTR, R/W. Write loads ptr = PWDATA[AW-1:0] mod DEPTH.
- 0x0C DATA, WO. Reads return 0.
- Offsets 0x10..0x1C: PSLVERR=1 in the access phase; writes have no effect; PRDATA=0.

APB handshake:
- Transfer completes in the access phase (PSEL & PENABLE) when PREADY=1.
- PREADY is combinational. It is 0 only when busy=1 and the access is a write to PTR or DATA. The slave holds these in wait states until busy falls.
- Reads and CTRL/STATUS accesses never wait.
- PRDATA is valid in the access phase.
- Register side effects occur on the completing cycle only.

FSM states: IDLE, BURST, FILL.
- IDLE -> BURST on completed DATA write:
  - Latch PWDATA; set busy=1.
  - On the next 4 cycles: ram_we=1, ram_waddr=ptr, ram_wdata = byte n, least-significant byte first; ptr increments each beat.
  - Return to IDLE after the 4th beat; busy=0 the cycle after the last beat.
  - First ram_we is 1 cycle after transfer completion. A back-to-back DATA write sees at most 4 wait states.
- IDLE -> FILL on CTRL write with FILL=1:
  - ptr=0, busy=1.
  - Write {8{FILL_VAL}} to addresses 0..DEPTH-1, one per cycle (DEPTH cycles).
  - End with ptr=0, then IDLE.
  - The same CTRL write also updates FILL_VAL and MASK_EN; the fill uses the new FILL_VAL.
- CTRL write with FILL=1 while busy: fill is not started, err is set; MASK_EN and FILL_VAL still update.

Pointer arithmetic:
- ptr increments modulo DEPTH; 1567 -> 0.
- A word beginning at ptr=1566 writes 1566, 1567, 0, 1.
- ram_waddr never exceeds DEPTH-1.

Simultaneous events:
- The STATUS err W1C and an err-set in the same cycle cannot coincide, since they are different registers and only one APB access completes per cycle.
- mask_en changes take effect the cycle after the CTRL write, independent of busy.

Test Plan:
- Reset, then read STATUS and CTRL -> PRDATA=0, PREADY=1, PSLVERR=0, ram_we never asserted.
- Write PTR=0x10, then DATA=0xA1B2C3D4 -> ram_we pulses on 4 consecutive cycles at addresses 0x10..0x13 with data D4, C3, B2, A1; read PTR=0x14.
- Write PTR=1566, then two back-to-back DATA writes -> addresses 1566, 1567, 0, 1, 2, 3, 4, 5; second write sees 1-4 wait states; no address >= 1568.
- CTRL=0x7 (fill with 1s, enable) -> mask_en=1 next cycle; 1568 writes of 0xFF to 0..1567; busy=1 throughout; a DATA write issued mid-fill stalls until fill end, then writes at ptr=0.
- CTRL FILL during a burst -> no fill; STATUS reads err=1 (0x3 while busy); write STATUS=0x2 -> err=0.
- Read offset 0x14 -> PSLVERR=1, PRDATA=0; assert PRESETn=0 mid-fill -> ram_we=0 from the next cycle, ptr=0, busy=0.
